ctrl_sequencer: RTL

//  Microcoded control unit directly upstream of the 8-bit ALU/shift/register datapath: drives its ctrl_bus
//  one micro-word per clock. Micro-program held in a writable DEPTH x 16 store, loaded while idle.

---
 rtl/ctrl_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - microcoded control sequencer; optional single-step via CTRL_SEQ_STEP_EN
module ctrl_sequencer #(
  parameter int AW     = 4,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     start_addr,
  input  logic [ITER_W-1:0] iter,
  input  logic              abort,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [15:0]       prog_wdata,
`ifdef CTRL_SEQ_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic [7:0]        ctrl_bus,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     pc
);

  localparam int DEPTH = 2 ** AW;
  // Stored word keeps only the usable target bits: {tgt[AW-1:0], op[1:0], ctrl[7:0]}
  localparam int WW = AW + 10;

  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_LOOP = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [WW-1:0]     mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [ITER_W-1:0] loop_cnt_q, loop_cnt_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     tgt_q, tgt_d;
  logic              issue_q, issue_d;
  logic [WW-1:0]     fetch;
  logic              step_gate;

`ifdef CTRL_SEQ_STEP_EN
  assign step_gate = !step_mode || step;
`else
  assign step_gate = 1'b1;
`endif

  generate
    if (AW < 6) begin : g_unused_tgt
      logic unused_tgt_bits;
      assign unused_tgt_bits = ^prog_wdata[15:AW+10];
    end
  endgenerate

  // Micro-store write port; only honoured while idle, contents survive reset
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) begin
      mem_q[prog_addr] <= prog_wdata[WW-1:0];
    end
  end

  // Next-state, sequencing and registered-output decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    op_d       = op_q;
    tgt_d      = tgt_q;
    issue_d    = 1'b0;
    ctrl_d     = 8'h00;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    fetch      = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_RUN;
          pc_d       = start_addr;
          loop_cnt_d = iter;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (issue_q) begin
          case (op_q)
            OP_HALT: state_d = S_DONE;
            OP_LOOP: begin
              if (loop_cnt_q != '0) begin
                loop_cnt_d = loop_cnt_q - ITER_W'(1);
                pc_d       = tgt_q;
              end else begin
                pc_d = pc_q + AW'(1);
              end
            end
            default: pc_d = pc_q + AW'(1);
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Fetch the word at the next pc so it is on ctrl_bus while pc holds that address
    if (state_d == S_RUN) begin
      fetch   = mem_q[pc_d];
      op_d    = fetch[9:8];
      tgt_d   = fetch[WW-1:10];
      issue_d = (state_q == S_IDLE) ? 1'b1 : step_gate;
      busy_d  = 1'b1;
      if (issue_d) begin
        ctrl_d = fetch[7:0];
      end
    end
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      loop_cnt_q <= '0;
      ctrl_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_q       <= 2'b00;
      tgt_q      <= '0;
      issue_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_q       <= op_d;
      tgt_q      <= tgt_d;
      issue_q    <= issue_d;
    end
  end

  assign ctrl_bus = ctrl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pc       = pc_q;

endmodule
